// File: rtl/pwm_fader_if.sv
// Purpose : control/status bundle for pwm_fader (fade enable, mode, PWM outputs, segment).
// Ports   : en, mode (driven by master); pwm_out[NUM_CH], seg (driven by slave = fader).
// Latency : n/a (wires only); backpressure: none, outputs are free-running levels.
interface pwm_fader_if #(
  parameter int NUM_CH = 3
);
  localparam int SEGW = $clog2(2 * NUM_CH);

  logic              en;
  logic              mode;
  logic [NUM_CH-1:0] pwm_out;
  logic [SEGW-1:0]   seg;

  modport master (output en, output mode, input pwm_out, input seg);
  modport slave  (input en, input mode, output pwm_out, output seg);
endinterface

// File: rtl/pwm_fader.sv
// Purpose : multi-channel PWM colour-wheel / breathe fader (e.g. RGB LED driver).
// Latency : duty changes reach pwm_out at the next PWM period boundary; seg is registered.
// Backpr. : none; en=0 freezes the fade, the PWM carrier keeps running.
// Ports   : clk, rst (async, active-high); bus.en, bus.mode in; bus.pwm_out, bus.seg out.
// Config  : define PWM_ACTIVE_LOW_EN to invert pwm_out (common-anode LEDs).
module pwm_fader #(
  parameter int NUM_CH       = 3,
  parameter int PWM_INTERVAL = 1200,
  parameter int DUTY_STEP    = 12,
  parameter int STEP_CYCLES  = 10000
) (
  input logic        clk,
  input logic        rst,
  pwm_fader_if.slave bus
);

  localparam int DW        = $clog2(PWM_INTERVAL + 1);
  localparam int SEGS      = 2 * NUM_CH;
  localparam int SEGW      = $clog2(SEGS);
  localparam int SEG_STEPS = PWM_INTERVAL / DUTY_STEP;
  localparam int TW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int KW        = (SEG_STEPS > 1) ? $clog2(SEG_STEPS) : 1;

  localparam logic [DW-1:0]   PI_V         = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0]   DS_V         = DW'(DUTY_STEP);
  localparam logic [DW-1:0]   PWM_LAST     = DW'(PWM_INTERVAL - 1);
  localparam logic [TW-1:0]   STEP_LAST    = TW'(STEP_CYCLES - 1);
  localparam logic [KW-1:0]   SEGSTEP_LAST = KW'(SEG_STEPS - 1);
  localparam logic [SEGW-1:0] SEG_LAST     = SEGW'(SEGS - 1);

  typedef enum logic [1:0] {ST_RISE, ST_HIGH, ST_FALL, ST_LOW} ch_state_e;

  // Channel position inside the wheel. Mode 0 staggers channel k by 2k
  // segments so each colour rises while its predecessor is still high.
  function automatic ch_state_e ch_state(input logic [SEGW-1:0] s, input int k, input logic m);
    int r;
    if (m) begin
      r = int'(s);
    end else begin
      r = int'(s) + SEGS - 2 * k;
      if (r >= SEGS) r = r - SEGS;
    end
    if (r == 0)           return ST_RISE;
    else if (r < NUM_CH)  return ST_HIGH;
    else if (r == NUM_CH) return ST_FALL;
    else                  return ST_LOW;
  endfunction

  // Duty a channel holds at seg=0, mode 0 (reset image).
  function automatic logic [DW-1:0] rst_duty(input int k);
    return (ch_state('0, k, 1'b0) == ST_HIGH) ? PI_V : '0;
  endfunction

  logic [DW-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [TW-1:0]     step_cnt_q, step_cnt_d;
  logic [KW-1:0]     seg_step_q, seg_step_d;
  logic [SEGW-1:0]   seg_q, seg_d;
  logic              mode_q, mode_d;
  logic [DW-1:0]     shadow_q [NUM_CH];
  logic [DW-1:0]     shadow_d [NUM_CH];
  logic [DW-1:0]     active_q [NUM_CH];
  logic [DW-1:0]     active_d [NUM_CH];
  logic              step_fire;
  logic              pwm_wrap;
  logic [NUM_CH-1:0] pwm_raw;

  always_comb begin
    // The terminal count always completes the step, even if en drops on it.
    step_fire  = (step_cnt_q == STEP_LAST);
    pwm_wrap   = (pwm_cnt_q == PWM_LAST);
    pwm_cnt_d  = pwm_wrap ? '0 : pwm_cnt_q + DW'(1);
    step_cnt_d = step_cnt_q;
    seg_step_d = seg_step_q;
    seg_d      = seg_q;
    mode_d     = mode_q;

    if (step_fire) begin
      step_cnt_d = '0;
    end else if (bus.en) begin
      step_cnt_d = step_cnt_q + TW'(1);
    end

    if (step_fire) begin
      if (seg_step_q == SEGSTEP_LAST) begin
        seg_step_d = '0;
        seg_d      = (seg_q == SEG_LAST) ? '0 : seg_q + SEGW'(1);
        // Mode only takes effect on a segment boundary so a wheel never
        // jumps mid-ramp.
        mode_d     = bus.mode;
      end else begin
        seg_step_d = seg_step_q + KW'(1);
      end
    end

    for (int k = 0; k < NUM_CH; k++) begin
      shadow_d[k] = shadow_q[k];
      if (step_fire) begin
        case (ch_state(seg_q, k, mode_q))
          ST_RISE: shadow_d[k] = (shadow_q[k] >= PI_V - DS_V) ? PI_V : shadow_q[k] + DS_V;
          ST_HIGH: shadow_d[k] = PI_V;
          ST_FALL: shadow_d[k] = (shadow_q[k] <= DS_V) ? '0 : shadow_q[k] - DS_V;
          default: shadow_d[k] = '0;
        endcase
      end
      // Compare value only changes at the period boundary; taking the
      // freshly stepped shadow lets a step landing on the wrap show up
      // in the very next period.
      active_d[k] = pwm_wrap ? shadow_d[k] : active_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      seg_step_q <= '0;
      seg_q      <= '0;
      mode_q     <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= rst_duty(k);
        active_q[k] <= rst_duty(k);
      end
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      seg_step_q <= seg_step_d;
      seg_q      <= seg_d;
      mode_q     <= mode_d;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  // duty = PWM_INTERVAL is never reached by the counter, so it yields 100 %.
  always_comb begin
    pwm_raw = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pwm_raw[k] = (pwm_cnt_q < active_q[k]);
    end
  end

`ifdef PWM_ACTIVE_LOW_EN
  assign bus.pwm_out = ~pwm_raw;
`else
  assign bus.pwm_out = pwm_raw;
`endif
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_pwm_fader.sv
// Bench for pwm_fader: table of per-period duty measurements from reset,
// hand sequences for freeze / mode-change / mid-run reset, then random en/mode/rst
// against a step-count based reference model.
module tb_pwm_fader;

  localparam int NUM_CH    = 3;
  localparam int PI        = 12;
  localparam int DS        = 4;
  localparam int SC        = 12;
  localparam int SEG_STEPS = PI / DS;
  localparam int SEGS      = 2 * NUM_CH;

`ifdef PWM_ACTIVE_LOW_EN
  localparam logic [2:0] INV = 3'b111;
`else
  localparam logic [2:0] INV = 3'b000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_fader_if #(.NUM_CH(NUM_CH)) bus();

  pwm_fader #(
    .NUM_CH(NUM_CH), .PWM_INTERVAL(PI), .DUTY_STEP(DS), .STEP_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model (tracks total steps since reset) ----------------
  int m_phase, m_timer, m_steps, m_mode;
  int m_sh [NUM_CH];
  int m_act[NUM_CH];

  function automatic int rel(input int s, input int k, input int md);
    if (md != 0) return s;
    return ((s - 2 * k) % SEGS + SEGS) % SEGS;
  endfunction

  function automatic int m_seg();
    return (m_steps / SEG_STEPS) % SEGS;
  endfunction

  function automatic logic [2:0] m_pwm();
    logic [2:0] p;
    for (int k = 0; k < NUM_CH; k++) p[k] = (m_phase < m_act[k]);
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_timer = 0; m_steps = 0; m_mode = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        int r;
        r = rel(0, k, 0);
        m_sh[k]  = (r >= 1 && r <= NUM_CH - 1) ? PI : 0;
        m_act[k] = m_sh[k];
      end
    end else begin
      if (m_timer == SC - 1) begin
        int s;
        s = m_seg();
        for (int k = 0; k < NUM_CH; k++) begin
          int r;
          r = rel(s, k, m_mode);
          if (r == 0)           m_sh[k] = (m_sh[k] + DS > PI) ? PI : m_sh[k] + DS;
          else if (r < NUM_CH)  m_sh[k] = PI;
          else if (r == NUM_CH) m_sh[k] = (m_sh[k] - DS < 0) ? 0 : m_sh[k] - DS;
          else                  m_sh[k] = 0;
        end
        m_steps++;
        if (m_steps % SEG_STEPS == 0) m_mode = int'(bus.mode);
        m_timer = 0;
      end else if (bus.en) begin
        m_timer++;
      end
      if (m_phase == PI - 1) begin
        m_phase = 0;
        for (int k = 0; k < NUM_CH; k++) m_act[k] = m_sh[k];
      end else begin
        m_phase++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at the negedge right after a period boundary: checks seg, then
  // counts high cycles per channel across one full PWM period.
  task automatic measure(input string nm, input int es, input int d0, input int d1, input int d2);
    int cnt[3];
    logic [2:0] p;
    cnt = '{0, 0, 0};
    check({nm, ".seg"}, 32'(bus.seg), es);
    for (int i = 0; i < PI; i++) begin
      p = bus.pwm_out ^ INV;
      for (int k = 0; k < 3; k++) if (p[k] === 1'b1) cnt[k]++;
      @(negedge clk);
    end
    check({nm, ".duty0"}, cnt[0], d0);
    check({nm, ".duty1"}, cnt[1], d1);
    check({nm, ".duty2"}, cnt[2], d2);
  endtask

  typedef struct {
    int p;     // PWM period index since reset release (== steps taken)
    int seg;
    int d0, d1, d2;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int cur;
    logic [2:0] pwm_exp;

    vecs[0]  = '{0,  0, 0,  0,  12};
    vecs[1]  = '{1,  0, 4,  0,  12};
    vecs[2]  = '{2,  0, 8,  0,  12};
    vecs[3]  = '{3,  1, 12, 0,  12};
    vecs[4]  = '{4,  1, 12, 0,  8};
    vecs[5]  = '{6,  2, 12, 0,  0};
    vecs[6]  = '{7,  2, 12, 4,  0};
    vecs[7]  = '{9,  3, 12, 12, 0};
    vecs[8]  = '{10, 3, 8,  12, 0};
    vecs[9]  = '{12, 4, 0,  12, 0};
    vecs[10] = '{13, 4, 0,  12, 4};
    vecs[11] = '{15, 5, 0,  12, 12};
    vecs[12] = '{16, 5, 0,  8,  12};
    vecs[13] = '{18, 0, 0,  0,  12};
    vecs[14] = '{19, 0, 4,  0,  12};

    bus.en   = 1'b1;
    bus.mode = 1'b0;

    // Reset state, observed while rst is held.
    rst = 1'b1;
    @(negedge clk);
    check("rst.pwm", 32'(bus.pwm_out), 32'(3'b100 ^ INV));
    check("rst.seg", 32'(bus.seg), 0);
    do_reset();

    // Table: fade wheel from reset, mode 0, en=1.
    cur = 0;
    for (int i = 0; i < 15; i++) begin
      adv(vecs[i].p * PI - cur);
      measure($sformatf("vec%0d", i), vecs[i].seg, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      cur = vecs[i].p * PI + PI;
    end

    // Freeze: en=0 with the step timer at 6 in step 2 of seg 0.
    do_reset();
    adv(30);
    bus.en = 1'b0;
    for (int e = 31; e <= 130; e++) begin
      @(negedge clk);
      pwm_exp = {1'b1, 1'b0, ((e % PI) < 8)};
      check($sformatf("frz.pwm@%0d", e), 32'(bus.pwm_out), 32'(pwm_exp ^ INV));
      check($sformatf("frz.seg@%0d", e), 32'(bus.seg), 0);
    end
    bus.en = 1'b1;
    adv(5);
    check("frz.seg_before_resume_step", 32'(bus.seg), 0);
    adv(1);
    check("frz.seg_after_resume_step", 32'(bus.seg), 1);

    // Mode change mid-segment only applies at the seg 0 -> 1 boundary.
    do_reset();
    adv(12);
    bus.mode = 1'b1;
    adv(12);
    measure("mode.p2", 0, 8, 0, 12);
    measure("mode.p3", 1, 12, 0, 12);
    measure("mode.p4", 1, 12, 12, 12);
    bus.mode = 1'b0;

    // Reset asserted mid-run at seg 4.
    do_reset();
    adv(150);
    check("mrst.seg_before", 32'(bus.seg), 4);
    rst = 1'b1;
    #1;
    check("mrst.pwm_now", 32'(bus.pwm_out), 32'(3'b100 ^ INV));
    check("mrst.seg_now", 32'(bus.seg), 0);
    @(negedge clk);
    rst = 1'b0;
    measure("mrst.p0", 0, 0, 0, 12);
    measure("mrst.p1", 0, 4, 0, 12);

    // Random en/mode/rst against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      check($sformatf("rnd.seg@%0d", i), 32'(bus.seg), m_seg());
      check($sformatf("rnd.pwm@%0d", i), 32'(bus.pwm_out), 32'(m_pwm() ^ INV));
      bus.en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
      rst = ($urandom_range(0, 999) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of PWM channels, minimum 2.
REQ-002 SHALL have parameter PWM_INTERVAL, default 1200: PWM period in clk cycles.
REQ-003 SHALL have parameter DUTY_STEP, default 12: duty change per fade step; PWM_INTERVAL SHALL be an integer multiple of DUTY_STEP.
REQ-004 SHALL have parameter STEP_CYCLES, default 10000: clk cycles between fade steps.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: 1 = fade advances, 0 = fade frozen.
REQ-008 SHALL have port mode, input, 1 bit: 0 = phase-staggered colour wheel, 1 = all channels in phase (breathe).
REQ-009 SHALL have port pwm_out, output, NUM_CH bits: per-channel PWM output.
REQ-010 SHALL have port seg, output, clog2(2*NUM_CH) bits: current fade segment.

Function
REQ-011 The PWM counter SHALL count 0..PWM_INTERVAL-1 and wrap to 0.
REQ-012 Channel k SHALL output active while counter < duty_k, with duty_k in 0..PWM_INTERVAL: 0 gives never-active, PWM_INTERVAL gives always-active.
REQ-013 Each channel SHALL hold a shadow duty; the value driving the compare SHALL load from it only at counter wrap, so no mid-period glitch occurs.
REQ-014 The step timer SHALL count 0..STEP_CYCLES-1 while en=1, hold while en=0, and produce one step on its terminal count.
REQ-015 There SHALL be 2*NUM_CH segments, each lasting PWM_INTERVAL/DUTY_STEP steps; seg SHALL wrap from 2*NUM_CH-1 to 0.
REQ-016 Channel k relative position SHALL be r = (seg - 2k) mod 2*NUM_CH in mode 0, and r = seg in mode 1.
REQ-017 Channel k state SHALL be RISE when r=0, HIGH when 1<=r<=NUM_CH-1, FALL when r=NUM_CH, and LOW when r>NUM_CH.
REQ-018 On each step the shadow duty SHALL update as follows: RISE adds DUTY_STEP, saturating at PWM_INTERVAL; FALL subtracts DUTY_STEP, saturating at 0; HIGH forces PWM_INTERVAL; LOW forces 0.
REQ-019 mode SHALL be sampled only at a segment boundary, on the step that advances seg; a mid-segment change SHALL have no effect until that point.
REQ-020 If en falls on the same cycle as a step terminal count, that step SHALL still complete.
REQ-021 The PWM counter SHALL free-run regardless of en.

Reset
REQ-022 rst=1 SHALL immediately clear the PWM counter, step timer, segment step count and seg, and SHALL force the mode register to 0.
REQ-023 During reset, each shadow and active duty SHALL be PWM_INTERVAL if the channel is HIGH at seg=0, mode 0, and 0 otherwise.
REQ-024 During reset, pwm_out SHALL reflect the reset duties, i.e. active only on HIGH channels.
REQ-025 Reset asserted mid-operation SHALL abort any in-progress step; operation SHALL resume from the REQ-022/REQ-023 state on the first edge after release.

Configuration
REQ-026 With macro PWM_ACTIVE_LOW_EN defined, pwm_out SHALL be inverted (active = 0), suitable for common-anode RGB LEDs.
REQ-027 Without PWM_ACTIVE_LOW_EN, pwm_out SHALL be active-high; no other behaviour changes.

Verification
Parameters for all scenarios: NUM_CH=3, PWM_INTERVAL=12, DUTY_STEP=4, STEP_CYCLES=12, macro undefined, unless stated otherwise.
REQ-028 Reset then release, en=1, mode=0: from cycle 0 pwm_out[2] SHALL be constantly 1 and pwm_out[1:0] SHALL be 0; after 12 cycles ch0 duty SHALL be 4 (high 4 of 12 cycles in the next period).
REQ-029 Run 3 steps: seg SHALL be 1 and ch0 duty 12; run 18 steps total: seg SHALL wrap to 0.
REQ-030 en=0 for 100 cycles mid-segment: duty and seg SHALL stay frozen while the PWM waveform continues unchanged; after en=1 the next step SHALL occur STEP_CYCLES minus the already-elapsed count later.
REQ-031 mode set to 1 at step 1 of seg 0: channels SHALL stay staggered until the seg 0 to 1 boundary, then all channels SHALL follow r=seg with equal duties.
REQ-032 Assert rst for 1 cycle at seg=4: all counters SHALL be 0 immediately, and pwm_out SHALL equal 3'b100 within the same cycle.
REQ-033 With PWM_ACTIVE_LOW_EN defined, repeat REQ-028: pwm_out SHALL be 3'b011 after reset.
